game_ctrl_seq: RTL

- Sequencer between OSD/user inputs and the ay38500NTSC chip's control pins.
- Owns the chip reset, the one-hot game-select bus, the option pins and the manual-serve pin.
- Any game/option change or user reset forces a frame-counted reset hold and a settle period before new settings go live.
- Serve requests become fixed-length, frame-counted serve pulses; re-triggers are ignored while a pulse is active.

---
 rtl/game_ctrl_if.sv | 27 ++
 rtl/game_ctrl_seq.sv | 136 +++++++++++++
 2 files changed

// File: rtl/game_ctrl_if.sv
// Control bundle between the OSD/user side and the game sequencer.
// master: drives requests (vs, cfg_game, cfg_opts, user_reset, serve_req)
//         and observes the chip-side pins.
// slave : the sequencer; consumes requests and drives chip_rst_n, game_sel,
//         opts, serve_n, busy.
interface game_ctrl_if;
  logic       vs;
  logic [2:0] cfg_game;
  logic [3:0] cfg_opts;
  logic       user_reset;
  logic       serve_req;
  logic       chip_rst_n;
  logic [7:0] game_sel;
  logic [3:0] opts;
  logic       serve_n;
  logic       busy;

  modport master (
    output vs, cfg_game, cfg_opts, user_reset, serve_req,
    input  chip_rst_n, game_sel, opts, serve_n, busy
  );

  modport slave (
    input  vs, cfg_game, cfg_opts, user_reset, serve_req,
    output chip_rst_n, game_sel, opts, serve_n, busy
  );
endinterface

// File: rtl/game_ctrl_seq.sv
// Sequencer driving the ay38500NTSC control pins from OSD/user inputs.
// Any game/option change or user reset holds the chip in reset for a fixed
// number of frames, then settles before settings go live. Serve requests
// become fixed-length frame-counted pulses on the manual-serve pin.
// Ports:
//   clk_sys - system clock, all logic on posedge
//   reset   - synchronous active-low reset
//   bus     - game_ctrl_if.slave: vs, cfg_game, cfg_opts, user_reset,
//             serve_req in; chip_rst_n, game_sel, opts, serve_n, busy out
//
// state  | meaning
// HOLD   | chip held in reset, latching requested config each cycle
// SETTLE | chip released, waiting before serves are accepted
// RUN    | normal play, serve pulses generated
module game_ctrl_seq #(
  parameter int unsigned HOLD_FRAMES   = 4,
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned SERVE_FRAMES  = 3,
  parameter int unsigned CW            = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  game_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {HOLD = 2'd0, SETTLE = 2'd1, RUN = 2'd2} state_t;

  localparam logic [CW-1:0] HOLD_C   = CW'(HOLD_FRAMES);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE_FRAMES);
  localparam logic [CW-1:0] SERVE_C  = CW'(SERVE_FRAMES);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CW-1:0] pulse, pulse_nx;
  logic [2:0]    app_game, app_game_nx, cfg_game_m;
  logic [3:0]    app_opts, app_opts_nx;
  logic          vs_d, srv_d, vs_rise, srv_rise, cfg_diff;
  logic          chip_rst_n_q, serve_n_q, busy_q;
  logic [7:0]    game_sel_q;
  logic [3:0]    opts_q;

  // Invalid game codes fall back to tennis so they never look like a change.
  assign cfg_game_m = (bus.cfg_game > 3'd4) ? 3'd0 : bus.cfg_game;
  assign vs_rise    = bus.vs & ~vs_d;
  assign srv_rise   = bus.serve_req & ~srv_d;
  assign cfg_diff   = {cfg_game_m, bus.cfg_opts} != {app_game, app_opts};

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    pulse_nx    = pulse;
    app_game_nx = app_game;
    app_opts_nx = app_opts;
    case (state)
      HOLD: begin
        app_game_nx = cfg_game_m;
        app_opts_nx = bus.cfg_opts;
        pulse_nx    = '0;
        if (bus.user_reset) begin
          cnt_nx = HOLD_C;
        end else if (vs_rise) begin
          if (cnt == ONE) begin
            state_nx = SETTLE;
            cnt_nx   = SETTLE_C;
          end else begin
            cnt_nx = cnt - ONE;
          end
        end
      end
      SETTLE: begin
        pulse_nx = '0;
        if (bus.user_reset || cfg_diff) begin
          state_nx = HOLD;
          cnt_nx   = HOLD_C;
        end else if (vs_rise) begin
          if (cnt == ONE) state_nx = RUN;
          else            cnt_nx   = cnt - ONE;
        end
      end
      RUN: begin
        if (bus.user_reset || cfg_diff) begin
          state_nx = HOLD;
          cnt_nx   = HOLD_C;
          pulse_nx = '0;
        end else if (srv_rise && pulse == '0) begin
          pulse_nx = SERVE_C;
        end else if (vs_rise && pulse != '0) begin
          pulse_nx = pulse - ONE;
        end
      end
      default: begin
        state_nx = HOLD;
        cnt_nx   = HOLD_C;
        pulse_nx = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values so each pin moves on the
  // cycle after its causing event, with no combinational path from inputs.
  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      state        <= HOLD;
      cnt          <= HOLD_C;
      pulse        <= '0;
      app_game     <= 3'd0;
      app_opts     <= 4'd0;
      vs_d         <= 1'b0;
      srv_d        <= 1'b0;
      chip_rst_n_q <= 1'b0;
      game_sel_q   <= 8'h01;
      opts_q       <= 4'd0;
      serve_n_q    <= 1'b1;
      busy_q       <= 1'b1;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      pulse        <= pulse_nx;
      app_game     <= app_game_nx;
      app_opts     <= app_opts_nx;
      vs_d         <= bus.vs;
      srv_d        <= bus.serve_req;
      chip_rst_n_q <= (state_nx != HOLD);
      game_sel_q   <= 8'h01 << app_game_nx;
      opts_q       <= app_opts_nx;
      serve_n_q    <= ~((state_nx == RUN) & (app_opts_nx[3] | (pulse_nx != '0)));
      busy_q       <= (state_nx != RUN);
    end
  end

  assign bus.chip_rst_n = chip_rst_n_q;
  assign bus.game_sel   = game_sel_q;
  assign bus.opts       = opts_q;
  assign bus.serve_n    = serve_n_q;
  assign bus.busy       = busy_q;
endmodule
